// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler_pkg
// Purpose  : Shared types and helpers for the UART TX scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } sched_state_t;

    localparam int DATA_W_DEF = 8;
    localparam int WD_W       = 16;

    // Index width for a requester vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler_rr_arbiter
// Purpose  : Combinational round-robin pick of the first request at/after rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler_rr_arbiter
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int w_best;
    int w_dist;

    // Cyclic distance from the pointer; the smallest distance among set requests wins.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j >= int'(rr_ptr)) ? (j - int'(rr_ptr)) : (j + NUM_REQ - int'(rr_ptr));
            if (req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                idx    = IDX_W'(j);
                gnt    = '0;
                gnt[j] = 1'b1;
            end
        end
        valid = (w_best < NUM_REQ);
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Round-robin sharing of one UART transmitter with watchdog and gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int          NUM_REQ    = 4,
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int          GAP_CYCLES = 2,
    parameter logic [15:0] TIMEOUT    = 16'd20000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      timeout,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      done_t,
    output logic                      busy
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [GAP_W-1:0] c_gap_load = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]  c_wd_last  = TIMEOUT - 16'd1;

    sched_state_t      r_state;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_owner;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [WD_W-1:0]   r_wd_cnt;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_valid;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_frame_end;

    uart_tx_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .gnt    (w_gnt),
        .idx    (w_idx),
        .valid  (w_valid)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) w_sel_data = data_in[i*DATA_W +: DATA_W];
        end
    end

    // done_t takes precedence over the watchdog when both land on the same cycle.
    assign w_frame_end = done_t || (r_wd_cnt == c_wd_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_gap_cnt <= '0;
            r_wd_cnt  <= '0;
            grant     <= '0;
            ack       <= '0;
            timeout   <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
        end else begin
            ack      <= '0;
            timeout  <= 1'b0;
            tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        grant    <= w_gnt;
                        r_owner  <= w_idx;
                        tx_data  <= w_sel_data;
                        r_wd_cnt <= '0;
                        busy     <= 1'b1;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    tx_start <= 1'b1;
                    r_state  <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (w_frame_end) begin
                        ack      <= grant;
                        grant    <= '0;
                        timeout  <= !done_t;
                        r_rr_ptr <= (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;
                        if (GAP_CYCLES > 0) begin
                            r_gap_cnt <= c_gap_load;
                            r_state   <= ST_GAP;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
